serial_cmd_initiator: RTL and testbench

- Host-side command master for the byte-serial command protocol used by the trigger boards. Lives on a master/controller board.
- Accepts one command at a time: opcode, 0-4 argument bytes, expected response length. Sends the opcode and arguments as bytes through a UART transmitter.
- Collects exactly the expected number of response bytes from a UART receiver, with a timeout.
- Mirrors the board-side command processor: opcode first, then argument bytes least significant first, then fixed-length reply.

---
 rtl/serial_cmd_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_serial_cmd_initiator.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_initiator.sv
// Host-side byte-serial command master: sends opcode + args over a UART, then collects a fixed-length reply.
// Optional statistics counters are enabled with `define SERIAL_CMD_INIT_STATS_EN.
module serial_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned MAX_RESP       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [2:0]  cmd_nargs,
    input  logic [31:0] cmd_args,
    input  logic [5:0]  cmd_nresp,
    input  logic        txBusy,
    output logic        txStart,
    output logic [7:0]  txData,
    input  logic        rxReady,
    input  logic [7:0]  rxData,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [4:0]  resp_index,
    output logic        done,
    output logic        timeout,
    output logic        rx_stray,
    output logic [15:0] cmd_count,
    output logic [15:0] timeout_count
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_RECV,
        ST_DONE
    } state_t;

    localparam logic [5:0]  MAX_RESP_C = 6'(MAX_RESP);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_buf [0:4];
    logic [2:0]  r_nargs;
    logic [5:0]  r_nresp;
    logic [2:0]  r_send_idx;
    logic [5:0]  r_count;
    logic [31:0] r_timer;
    logic        r_cmd_ready;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_resp_valid;
    logic [7:0]  r_resp_data;
    logic [4:0]  r_resp_index;
    logic        r_done;
    logic        r_timeout;
    logic        r_rx_stray;

    logic [7:0]  w_load_byte [0:4];
    logic [2:0]  w_nargs_clamped;
    logic [5:0]  w_nresp_clamped;
    logic        w_accept;
    logic        w_timer_expired;
    logic        w_last_byte;
    logic        w_expire_now;

    // Wire order: opcode first, then argument bytes least significant first.
    assign w_load_byte[0] = cmd_opcode;
    for (genvar gi = 0; gi < 4; gi++) begin : g_arg_bytes
        assign w_load_byte[gi+1] = cmd_args[8*gi +: 8];
    end

    assign w_nargs_clamped = (cmd_nargs > 3'd4) ? 3'd4 : cmd_nargs;
    assign w_nresp_clamped = (cmd_nresp > MAX_RESP_C) ? MAX_RESP_C : cmd_nresp;
    assign w_accept        = (r_state == ST_IDLE) && cmd_valid;
    assign w_timer_expired = (r_timer >= TIMER_LAST);
    assign w_last_byte     = ((r_count + 6'd1) == r_nresp);
    assign w_expire_now    = (r_state == ST_RECV) && !rxReady && w_timer_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            for (int i = 0; i < 5; i++) begin
                r_buf[i] <= '0;
            end
            r_nargs      <= '0;
            r_nresp      <= '0;
            r_send_idx   <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_cmd_ready  <= 1'b1;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_index <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_rx_stray   <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_done       <= 1'b0;
            r_rx_stray   <= rxReady && (r_state != ST_RECV);
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < 5; i++) begin
                            r_buf[i] <= w_load_byte[i];
                        end
                        r_nargs     <= w_nargs_clamped;
                        r_nresp     <= w_nresp_clamped;
                        r_send_idx  <= '0;
                        r_timeout   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!txBusy) begin
                        r_tx_data  <= r_buf[r_send_idx];
                        r_tx_start <= 1'b1;
                        r_state    <= ST_GAP;
                    end
                end
                // The UART only raises txBusy a cycle after txStart, so SEND must not be re-entered directly.
                ST_GAP: begin
                    if (r_send_idx < r_nargs) begin
                        r_send_idx <= r_send_idx + 3'd1;
                        r_state    <= ST_SEND;
                    end else if (r_nresp == 6'd0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= '0;
                        r_timer <= '0;
                        r_state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (rxReady) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= rxData;
                        r_resp_index <= r_count[4:0];
                        r_count      <= r_count + 6'd1;
                        r_timer      <= '0;
                        if (w_last_byte) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (w_timer_expired) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (r_timer != 32'hFFFF_FFFF) begin
                        r_timer <= r_timer + 32'd1;
                    end
                end
                ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_CMD_INIT_STATS_EN
    logic [15:0] r_cmd_count;
    logic [15:0] r_timeout_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_count     <= '0;
            r_timeout_count <= '0;
        end else begin
            if (w_accept) begin
                r_cmd_count <= r_cmd_count + 16'd1;
            end
            if (w_expire_now) begin
                r_timeout_count <= r_timeout_count + 16'd1;
            end
        end
    end

    assign cmd_count     = r_cmd_count;
    assign timeout_count = r_timeout_count;
`else
    logic w_stats_unused;
    assign w_stats_unused = w_accept ^ w_expire_now;
    assign cmd_count      = '0;
    assign timeout_count  = '0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign txStart    = r_tx_start;
    assign txData     = r_tx_data;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_index = r_resp_index;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign rx_stray   = r_rx_stray;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Self-checking bench for serial_cmd_initiator: a transaction-level model predicts wire bytes,
// response strobes, done/timeout timing and counters; directed commands exercise each scenario.
module tb_serial_cmd_initiator;
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [2:0]  cmd_nargs = '0;
    logic [31:0] cmd_args = '0;
    logic [5:0]  cmd_nresp = '0;
    logic        txBusy = 1'b0;
    logic        txStart;
    logic [7:0]  txData;
    logic        rxReady = 1'b0;
    logic [7:0]  rxData = '0;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [4:0]  resp_index;
    logic        done;
    logic        timeout;
    logic        rx_stray;
    logic [15:0] cmd_count;
    logic [15:0] timeout_count;

    always #5 clk = ~clk;

    serial_cmd_initiator #(.TIMEOUT_CYCLES(T), .MAX_RESP(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_nargs(cmd_nargs), .cmd_args(cmd_args), .cmd_nresp(cmd_nresp),
        .txBusy(txBusy), .txStart(txStart), .txData(txData),
        .rxReady(rxReady), .rxData(rxData),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_index(resp_index),
        .done(done), .timeout(timeout), .rx_stray(rx_stray),
        .cmd_count(cmd_count), .timeout_count(timeout_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accept detection: sampled at the active edge, before the DUT updates cmd_ready.
    int          acc_cyc = -1;
    logic [7:0]  acc_op;
    logic [2:0]  acc_nargs;
    logic [31:0] acc_args;
    logic [5:0]  acc_nresp;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && cmd_valid && cmd_ready) begin
                acc_cyc   = cyc;
                acc_op    = cmd_opcode;
                acc_nargs = cmd_nargs;
                acc_args  = cmd_args;
                acc_nresp = cmd_nresp;
            end
        end
    end

    // Stimulus record of rxReady pulses: 1 = response byte, 2 = stray byte.
    int         kind_q [int];
    logic [7:0] rdat_q [int];

    logic [7:0] exp_tx [$];
    logic [7:0] tx_log [$];
    logic [7:0] resp_log [$];
    logic [4:0] ridx_log [$];
    int         tx_seen = 0;
    int         stray_cnt = 0;

    // Transaction model, UART transmitter model and per-cycle comparison.
    initial begin
        bit m_active;
        int m_nresp, m_got, m_tx_done_cyc, m_last_resp_cyc, m_cmds, m_tos;
        int busy_cnt, k, n, ref_cyc;
        bit prev_tx, exp_rv, exp_st, exp_done, exp_to;
        m_active = 0; m_cmds = 0; m_tos = 0; busy_cnt = 0; prev_tx = 0;
        m_nresp = 0; m_got = 0; m_tx_done_cyc = -1; m_last_resp_cyc = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_txStart", txStart, 0);
                chk("rst_done", done, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_resp_valid", resp_valid, 0);
                m_active = 0; m_cmds = 0; m_tos = 0;
                exp_tx.delete();
                prev_tx = 0; busy_cnt = 0; txBusy = 0;
            end else begin
                if (acc_cyc == cyc) begin
                    m_active = 1;
                    m_nresp = (acc_nresp > 6'd32) ? 32 : int'(acc_nresp);
                    m_got = 0; m_tx_done_cyc = -1; m_last_resp_cyc = -1;
                    n = (acc_nargs > 3'd4) ? 4 : int'(acc_nargs);
                    exp_tx.push_back(acc_op);
                    for (int i = 0; i < n; i++) exp_tx.push_back(acc_args[8*i +: 8]);
                    m_cmds++;
                end
                chk("cmd_ready", cmd_ready, !m_active);

                if (txStart) begin
                    chk("tx_not_back_to_back", prev_tx, 0);
                    chk("tx_busy_honoured", txBusy, 0);
                    chk("tx_pending", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) chk("txData", txData, exp_tx.pop_front());
                    tx_log.push_back(txData);
                    tx_seen++;
                    if (exp_tx.size() == 0) m_tx_done_cyc = cyc;
                end
                prev_tx = txStart;
                if (txStart) busy_cnt = 10;
                else if (busy_cnt > 0) busy_cnt--;
                txBusy = (busy_cnt != 0);

                k = kind_q.exists(cyc - 1) ? kind_q[cyc - 1] : 0;
                exp_rv = (k == 1);
                exp_st = (k == 2);
                if (resp_valid || exp_rv) begin
                    chk("resp_valid", resp_valid, exp_rv);
                    if (exp_rv) begin
                        chk("resp_data", resp_data, rdat_q[cyc - 1]);
                        chk("resp_index", resp_index, m_got);
                    end
                end
                if (resp_valid) begin
                    resp_log.push_back(resp_data);
                    ridx_log.push_back(resp_index);
                end
                if (exp_rv) begin
                    m_got++;
                    m_last_resp_cyc = cyc;
                end
                if (rx_stray || exp_st) chk("rx_stray", rx_stray, exp_st);
                if (rx_stray) stray_cnt++;

                exp_done = 0;
                exp_to = 0;
                if (m_active && exp_tx.size() == 0 && m_tx_done_cyc >= 0) begin
                    if (m_nresp == 0) begin
                        exp_done = (cyc == m_tx_done_cyc + 1);
                    end else if (m_got >= m_nresp) begin
                        exp_done = (cyc == m_last_resp_cyc);
                    end else begin
                        exp_to = 1;
                        ref_cyc = (m_got > 0) ? m_last_resp_cyc : m_tx_done_cyc + 1;
                        exp_done = (cyc == ref_cyc + T);
                    end
                end
                if (done || exp_done) begin
                    chk("done", done, exp_done);
                    if (exp_done) chk("timeout_flag", timeout, exp_to);
                end
                if (exp_done && exp_to) m_tos++;
                if (done) m_active = 0;
`ifdef SERIAL_CMD_INIT_STATS_EN
                chk("cmd_count", cmd_count, 32'(16'(m_cmds)));
                chk("timeout_count", timeout_count, 32'(16'(m_tos)));
`else
                chk("cmd_count_tied", cmd_count, 0);
                chk("timeout_count_tied", timeout_count, 0);
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] na, input logic [31:0] args,
                         input logic [5:0] nr);
        int w;
        tx_log.delete(); resp_log.delete(); ridx_log.delete();
        tx_seen = 0; stray_cnt = 0;
        cmd_opcode = op; cmd_nargs = na; cmd_args = args; cmd_nresp = nr;
        cmd_valid = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (acc_cyc != cyc && w < 50);
        chk("accept_seen", acc_cyc == cyc, 1);
        cmd_valid = 1'b0;
        $display("cmd op=%02h nargs=%0d args=%08h nresp=%0d accepted at cycle %0d", op, na, args, nr, cyc);
    endtask

    task automatic wait_tx(input int n);
        int w = 0;
        while (tx_seen < n && w < 500) begin
            tick();
            w++;
        end
        chk("tx_bytes_seen", tx_seen >= n, 1);
    endtask

    task automatic rx_byte(input logic [7:0] d, input int kind);
        rxReady = 1'b1;
        rxData = d;
        kind_q[cyc] = kind;
        rdat_q[cyc] = d;
        tick();
        rxReady = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int w = 0;
        while (!done && w < 2000) begin
            tick();
            w++;
        end
        chk("done_seen", done, 1);
        dc = cyc;
        $display("done at cycle %0d timeout=%0b tx_bytes=%0d resp_bytes=%0d", cyc, timeout, tx_log.size(), resp_log.size());
    endtask

    initial begin
        logic [7:0] pre [5];
        int dc, last_drive;
        pre = '{8'h07, 8'h78, 8'h56, 8'h34, 8'h12};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_txData", txData, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_index", resp_index, 0);
        chk("reset_timeout", timeout, 0);

        // Version query
        issue(8'h00, 3'd0, 32'h0, 6'd1);
        wait_tx(1);
        repeat (3) tick();
        rx_byte(8'h04, 1);
        wait_done(dc);
        chk("ver_tx_n", tx_log.size(), 1);
        if (tx_log.size() > 0) chk("ver_tx0", tx_log[0], 8'h00);
        chk("ver_resp_n", resp_log.size(), 1);
        if (resp_log.size() > 0) chk("ver_resp0", resp_log[0], 8'h04);
        chk("ver_timeout", timeout, 0);
        tick();

        // Prescale: four arguments, no response
        issue(8'h07, 3'd4, 32'h12345678, 6'd0);
        wait_done(dc);
        chk("pre_tx_n", tx_log.size(), 5);
        for (int i = 0; i < 5 && i < tx_log.size(); i++) chk("pre_tx_byte", tx_log[i], pre[i]);
        chk("pre_resp_n", resp_log.size(), 0);
        chk("pre_timeout", timeout, 0);
        tick();

        // Histogram read: 32 bytes with random gaps
        issue(8'h0A, 3'd0, 32'h0, 6'd32);
        wait_tx(1);
        repeat (3) tick();
        for (int i = 0; i < 32; i++) begin
            rx_byte(8'(i), 1);
            if (i < 31) repeat ($urandom_range(0, 20)) tick();
        end
        wait_done(dc);
        chk("hist_resp_n", resp_log.size(), 32);
        for (int i = 0; i < resp_log.size(); i++) chk("hist_index_eq_data", ridx_log[i], resp_log[i][4:0]);
        chk("hist_timeout", timeout, 0);
        tick();

        // Timeout: 5 of 16 bytes arrive
        issue(8'h0B, 3'd0, 32'h0, 6'd16);
        wait_tx(1);
        repeat (3) tick();
        last_drive = 0;
        for (int i = 0; i < 5; i++) begin
            last_drive = cyc;
            rx_byte(8'hC0 + 8'(i), 1);
            if (i < 4) repeat (2) tick();
        end
        wait_done(dc);
        chk("to_latency", dc - (last_drive + 1), T);
        chk("to_flag", timeout, 1);
        chk("to_resp_n", resp_log.size(), 5);
`ifdef SERIAL_CMD_INIT_STATS_EN
        chk("to_timeout_count", timeout_count, 1);
`endif
        repeat (3) tick();
        chk("to_flag_held", timeout, 1);

        // Stray byte during SEND and nargs clamp
        issue(8'h21, 3'd7, 32'hA1B2C3D4, 6'd2);
        chk("timeout_cleared", timeout, 0);
        wait_tx(1);
        repeat (2) tick();
        rx_byte(8'hEE, 2);
        wait_tx(5);
        repeat (3) tick();
        rx_byte(8'h55, 1);
        rx_byte(8'h66, 1);
        wait_done(dc);
        chk("clamp_tx_n", tx_log.size(), 5);
        if (tx_log.size() == 5) chk("clamp_tx_last", tx_log[4], 8'hA1);
        chk("stray_count", stray_cnt, 1);
        chk("stray_resp_n", resp_log.size(), 2);
        if (resp_log.size() > 0) chk("stray_not_delivered", resp_log[0], 8'h55);
        tick();

        // Reset during the third argument byte
        issue(8'h33, 3'd4, 32'hDEADBEEF, 6'd4);
        wait_tx(4);
        chk("mid_txStart_before", txStart, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_txStart_async", txStart, 0);
        chk("mid_ready_async", cmd_ready, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("mid_ready_after", cmd_ready, 1);
        chk("mid_no_done", done, 0);

        // Normal command after reset
        issue(8'h00, 3'd1, 32'h0000005A, 6'd1);
        wait_tx(2);
        repeat (3) tick();
        rx_byte(8'h99, 1);
        wait_done(dc);
        chk("post_tx_n", tx_log.size(), 2);
        if (tx_log.size() == 2) chk("post_tx_arg", tx_log[1], 8'h5A);
        chk("post_resp_n", resp_log.size(), 1);
        if (resp_log.size() > 0) chk("post_resp", resp_log[0], 8'h99);
        chk("post_timeout", timeout, 0);
`ifdef SERIAL_CMD_INIT_STATS_EN
        chk("post_cmd_count", cmd_count, 1);
`endif
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
